// File: rtl/bcd_converter_8b_pkg.sv
// Shared types and constants for the 8-bit binary to 3-digit BCD converter.
package bcd_converter_8b_pkg;

    localparam int N_BITS         = 8;
    localparam int N_DIGITS       = 3;
    localparam int N_SHIFTS       = 8;
    localparam int ADD3_THRESHOLD = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_converter_8b_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
    import bcd_converter_8b_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'(ADD3_THRESHOLD)) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_converter_8b.sv
// Iterative 8-bit binary to BCD converter (shift-add-3, one shift per clock).
module bcd_converter_8b
    import bcd_converter_8b_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    state_t                    state_q, state_d;
    logic [N_BITS-1:0]         shreg_q;
    logic [4*N_DIGITS-1:0]     scratch_q;
    logic [4*N_DIGITS-1:0]     adjusted;
    logic [4*N_DIGITS-1:0]     scratch_next;
    logic [3:0]                cnt_q;
    logic                      done_q;
    logic [11:0]               bcd_q;
    logic                      last_shift;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch_q[4*i +: 4]),
            .adjusted (adjusted[4*i +: 4])
        );
    end

    // Adjust first, then shift the top bit of the binary register into the units digit.
    assign scratch_next = {adjusted[4*N_DIGITS-2:0], shreg_q[N_BITS-1]};
    assign last_shift   = (cnt_q == 4'(N_SHIFTS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_next;
                    shreg_q   <= {shreg_q[N_BITS-2:0], 1'b0};
                    cnt_q     <= cnt_q + 4'd1;
                    if (last_shift) begin
                        bcd_q  <= scratch_next;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_converter_8b.sv
// Scoreboard bench for bcd_converter_8b: expected results queued at acceptance, checked on done.
module tb_bcd_converter_8b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];

    bcd_converter_8b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bcd), 32'hFFFF_FFFF);
            end else begin
                check("bcd_result", 32'(bcd), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic accept(input logic [7:0] v, input logic [11:0] exp, input bit push);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // n0 is the index of the current negedge counted from the accepting edge (1 = just after it).
    task automatic wait_done(input int n0, input logic [11:0] hold, input string tag);
        int n      = n0;
        int busy_n = 0;
        bit hold_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            if (bcd !== hold) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'd9);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(9 - n0));
        check({tag, "_bcd_held"}, 32'(hold_ok), 32'd1);
    endtask

    task automatic convert(input logic [7:0] v, input logic [11:0] exp,
                           input logic [11:0] hold, input string tag);
        accept(v, exp, 1'b1);
        wait_done(1, hold, tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'h000);
        rst_n = 1'b1;
        @(negedge clk);

        convert(8'd0,   12'h000, 12'h000, "zero");
        convert(8'd255, 12'h255, 12'h000, "max");
        convert(8'd100, 12'h100, 12'h255, "hundred");
        convert(8'd99,  12'h099, 12'h100, "ninetynine");
        convert(8'd123, 12'h123, 12'h099, "v123");
        convert(8'd7,   12'h007, 12'h123, "hold_prev");

        // start/bin wiggled while busy must be ignored
        accept(8'd37, 12'h037, 1'b1);
        start = 1'b1;
        bin   = 8'd200;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(4, 12'h007, "ignore_busy");
        @(negedge clk);
        check("ignore_busy_single_done", 32'(done), 32'd0);
        check("ignore_busy_no_restart", 32'(busy), 32'd0);

        // reset after four shifts aborts the conversion
        accept(8'd255, 12'h255, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_bcd_stays", 32'(bcd), 32'h000);
        convert(8'd42, 12'h042, 12'h000, "after_abort");

        // exhaustive back-to-back with start held high
        start = 1'b1;
        for (int v = 0; v < 256; v++) begin
            bin = 8'(v);
            @(posedge clk);
            exp_q.push_back(to_bcd(v));
            @(negedge clk);
            bin = 8'(v) ^ 8'h5A;
            wait_done(1, (v == 0) ? 12'h042 : to_bcd(v - 1), "b2b");
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_done_one_cycle", 32'(done), 32'd0);
        check("b2b_idle_after", 32'(busy), 32'd0);
        check("b2b_last_bcd", 32'(bcd), 32'h255);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
